// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Imported by mem_arb_starve_cnt and mem_arbiter.
package mem_arb_pkg;

    // Width of the starvation (hold) counter; holds MAX_HOLD values up to 15.
    localparam int HOLD_W = 4;

    // Debug encoding of the current grant owner.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    // Arbiter state: which requester received the most recent grant.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Map the registered state onto the owner debug code.
    function automatic owner_t state_to_owner(input state_t s);
        case (s)
            OWN0:    return OWN_M0;
            OWN1:    return OWN_M1;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating hold counter used as the arbiter's starvation guard.
// Counts consecutive m0 grants while m1 waits; at_max_o forces an m1 grant.
// Priority of controls: freeze, then clear, then increment.
// MAX_HOLD must lie in 1..15 so it fits the HOLD_W-bit counter.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    input  logic freeze_i,
    output logic at_max_o
);

    localparam logic [HOLD_W-1:0] MAX_VAL = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    // Next count: hold while frozen, clear when m1 is served or idle, else saturate upward.
    always_comb begin
        cnt_d = cnt_q;
        if (freeze_i) begin
            cnt_d = cnt_q;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_VAL)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with asynchronous reset to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory.
// m0 (core) has fixed priority; m1 (debug/loader) is forced through after
// MAX_HOLD consecutive m0 grants. Read data returns one cycle after grant.
// Optional bus locking for atomic read-modify-write: define MEM_ARB_LOCK_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
`ifdef MEM_ARB_LOCK_EN
    input  logic          m0_lock_i,
`endif
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,

    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
`ifdef MEM_ARB_LOCK_EN
    input  logic          m1_lock_i,
`endif
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o,

    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_we_o,
    output logic          mem_en_o,
    input  logic [DW-1:0] mem_rdata_i,

    output logic [1:0]    owner_o
);

    state_t        state_q, state_d;
    logic          tag_valid_q, tag_valid_d;
    logic          tag_id_q, tag_id_d;
    logic [DW-1:0] m0_hold_q, m0_hold_d;
    logic [DW-1:0] m1_hold_q, m1_hold_d;

    logic req0, req1;
    logic gnt0, gnt1;
    logic at_max;
    logic block_m0, block_m1;
    logic freeze;

`ifdef MEM_ARB_LOCK_EN
    // Only the registered owner's lock counts; a lock from the other side is ignored.
    assign block_m1 = (state_q == OWN1) ? 1'b0 : ((state_q == OWN0) && m0_lock_i);
    assign block_m0 = (state_q == OWN0) ? 1'b0 : ((state_q == OWN1) && m1_lock_i);
`else
    assign block_m1 = 1'b0;
    assign block_m0 = 1'b0;
`endif
    assign freeze = block_m0 | block_m1;

    // Sanitise requests so that an unknown request level never wins a grant.
    always_comb begin
        req0 = 1'b0;
        req1 = 1'b0;
        case (m0_req_i)
            1'b1:    req0 = 1'b1;
            default: req0 = 1'b0;
        endcase
        case (m1_req_i)
            1'b1:    req1 = 1'b1;
            default: req1 = 1'b0;
        endcase
    end

    // Grant decision: m0 first, m1 when alone, starved, or m0 is locked out.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case ({req1, req0})
                2'b01: gnt0 = !block_m0;
                2'b10: gnt1 = !block_m1;
                2'b11: begin
                    if (block_m1) begin
                        gnt0 = 1'b1;
                    end else if (block_m0) begin
                        gnt1 = 1'b1;
                    end else if (at_max) begin
                        gnt1 = 1'b1;
                    end else begin
                        gnt0 = 1'b1;
                    end
                end
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
        end
    end

    // Steer the winner onto the memory port; everything reads zero when idle.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (gnt0) begin
            mem_en_o    = 1'b1;
            mem_we_o    = m0_we_i;
            mem_addr_o  = m0_addr_i;
            mem_wdata_o = m0_wdata_i;
        end else if (gnt1) begin
            mem_en_o    = 1'b1;
            mem_we_o    = m1_we_i;
            mem_addr_o  = m1_addr_i;
            mem_wdata_o = m1_wdata_i;
        end
    end

    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    mem_arb_starve_cnt #(
        .MAX_HOLD (MAX_HOLD)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (gnt0 && req1),
        .clr_i    (gnt1 || !req1),
        .freeze_i (freeze),
        .at_max_o (at_max)
    );

    // Next owner state plus read-return tag and per-requester rdata hold values.
    always_comb begin
        state_d     = IDLE;
        tag_valid_d = 1'b0;
        tag_id_d    = 1'b0;
        m0_hold_d   = m0_hold_q;
        m1_hold_d   = m1_hold_q;

        if (gnt0) begin
            state_d = OWN0;
        end else if (gnt1) begin
            state_d = OWN1;
        end

        tag_valid_d = (gnt0 || gnt1) && !mem_we_o;
        tag_id_d    = gnt1;

        m0_rvalid_o = tag_valid_q && !tag_id_q;
        m1_rvalid_o = tag_valid_q && tag_id_q;
        m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : m0_hold_q;
        m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : m1_hold_q;

        if (m0_rvalid_o) begin
            m0_hold_d = mem_rdata_i;
        end
        if (m1_rvalid_o) begin
            m1_hold_d = mem_rdata_i;
        end
    end

    // State register; reset drops any read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tag_valid_q <= 1'b0;
            tag_id_q    <= 1'b0;
            m0_hold_q   <= '0;
            m1_hold_q   <= '0;
        end else begin
            state_q     <= state_d;
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
            m0_hold_q   <= m0_hold_d;
            m1_hold_q   <= m1_hold_d;
        end
    end

    assign owner_o = state_to_owner(state_q);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous program/data memory between two requesters.
  - m0: the processor core, i.e. control-unit fetch and store traffic.
  - m1: a debug/program-loader port.
- Issues at most one memory access per cycle.
- Arbitration is fixed-priority towards m0, with a starvation guard that forces an m1 grant after MAX_HOLD consecutive m0 grants.
- Returns read data to the issuing requester one cycle after the grant.

Parameters:
- AW, 8: address width.
- DW, 8: data width.
- MAX_HOLD, 4: max consecutive m0 grants while m1 is pending; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- m0_req  in  1  m0 access request; held until m0_gnt.
- m0_we  in  1  m0 write enable (1 = write, 0 = read).
- m0_addr  in  AW  m0 address.
- m0_wdata  in  DW  m0 write data.
- m0_gnt  out  1  m0 access issued to memory this cycle.
- m0_rvalid  out  1  m0 read data valid.
- m0_rdata  out  DW  m0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0 ports, for m1.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_we  out  1  memory write strobe.
- mem_en  out  1  memory access enable.
- mem_rdata  in  DW  memory read data; valid the cycle after mem_en with mem_we=0.
- owner  out  2  current grant owner, for debug.

Behaviour:
- Reset (rst high, asynchronous):
  - state = IDLE; hold_cnt = 0; read-return tag cleared.
  - All gnt/rvalid = 0; mem_en = 0; mem_we = 0.
  - mem_addr, mem_wdata = 0; owner = OWN_NONE.
- Grant decision is combinational from req and registered state.
  - gnt is a one-cycle pulse in the issue cycle.
  - Winner's addr/wdata/we drive the mem_* ports combinationally that cycle; mem_en = 1.
- Arbitration:
  - Only m0_req: grant m0.
  - Only m1_req: grant m1.
  - Both requesting: grant m0 unless hold_cnt == MAX_HOLD, then grant m1.
  - Neither requesting: no grant; mem_en = 0.
- hold_cnt (registered):
  - Increments on an m0 grant while m1_req = 1; saturates at MAX_HOLD.
  - Clears on any m1 grant and on any cycle with m1_req = 0.
- State machine, registered, tracking last owner:
  - IDLE -> OWN0 on an m0 grant; IDLE -> OWN1 on an m1 grant.
  - OWN0 / OWN1 -> IDLE on a cycle with no grant.
  - OWN0 / OWN1 -> the other state on a grant to the other requester.
  - owner encodes the state: OWN_NONE = 0, OWN_M0 = 1, OWN_M1 = 2.
- Read return:
  - A read grant sets the tag (valid + requester id) for one cycle.
  - Next cycle: the tagged mX_rvalid = 1 and mX_rdata = mem_rdata.
  - The other requester's rdata holds its last value; rvalid stays 0.
- Writes: no rvalid; the write completes in the grant cycle.
- Back-to-back: a new grant is permitted in the same cycle as the previous read's rvalid; throughput is 1 access/cycle.
- Requester dropping req before gnt: legal, nothing issued.
- Reset mid-read: the pending rvalid is dropped and never asserted after reset deasserts.
- Unknown/X req treated as 0 (implementation must default the case to no grant).

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- When defined:
  - Adds ports m0_lock and m1_lock (in, 1).
  - While the current owner's lock = 1, the other requester is never granted.
  - hold_cnt is frozen while lock is held; this is used for atomic read-modify-write.
  - Lock on a non-owner is ignored.
  - Owner deasserting lock restores normal arbitration in the same cycle.
- When undefined: no lock ports; arbitration exactly as above.

Decomposition:
- Package mem_arb_pkg:
  - owner_t enum {OWN_NONE, OWN_M0, OWN_M1} (2-bit).
  - Constant HOLD_W = 4 for the hold_cnt width.
- Sub-module mem_arb_starve_cnt: saturating hold counter with inc/clr/freeze inputs and at_max output. Natural to split out; everything else stays in mem_arbiter.

Test Plan:
- Reset with m0 read pending -> rst pulse mid-read; after release, m0_rvalid never asserts; owner = 0; mem_en = 0.
- m0 read only (addr 0x10, mem holds 0xA5) -> m0_gnt and mem_en in cycle N; m0_rvalid = 1 and m0_rdata = 0xA5 in N+1; owner = 1.
- m0 and m1 requesting continuously, MAX_HOLD = 4 -> grant pattern m0,m0,m0,m0,m1 repeating; hold_cnt returns to 0 after each m1 grant.
- m1 write alone (addr 0x20, data 0x3C), then m0 read of 0x20 -> mem_we = 1 with mem_wdata = 0x3C in cycle N; m0 reads 0x3C; m1_rvalid stays 0.
- Back-to-back reads m1 0x01 then m0 0x02 (mem 0x11/0x22) -> m1_rvalid with 0x11 in the cycle m0_gnt = 1; m0_rvalid with 0x22 the next cycle; no rvalid cross-talk.
- MEM_ARB_LOCK_EN: m0 owns with m0_lock = 1 and m1_req = 1 for 10 cycles -> no m1_gnt and hold_cnt frozen; m1 granted the cycle after lock drops with m0_req = 0.
